// File: rtl/hamm_decode_pipe_pkg.sv
// Hamming(7,4) codeword layout, syndrome codes and reference encoder shared by
// the decoder, the upstream encoder and the bench.
package hamm_decode_pipe_pkg;

  localparam int D0 = 0;
  localparam int D1 = 1;
  localparam int D2 = 2;
  localparam int D3 = 3;
  localparam int P0 = 4;
  localparam int P1 = 5;
  localparam int P2 = 6;

  localparam logic [2:0] SYN_NONE = 3'b000;
  localparam logic [2:0] SYN_D0   = 3'b011;
  localparam logic [2:0] SYN_D1   = 3'b101;
  localparam logic [2:0] SYN_D2   = 3'b110;
  localparam logic [2:0] SYN_D3   = 3'b111;
  localparam logic [2:0] SYN_P0   = 3'b001;
  localparam logic [2:0] SYN_P1   = 3'b010;
  localparam logic [2:0] SYN_P2   = 3'b100;

  function automatic logic [6:0] hamm_encode(input logic [3:0] d);
    logic [6:0] cw;
    cw     = '0;
    cw[D0] = d[0];
    cw[D1] = d[1];
    cw[D2] = d[2];
    cw[D3] = d[3];
    cw[P0] = d[0] ^ d[1] ^ d[3];
    cw[P1] = d[0] ^ d[2] ^ d[3];
    cw[P2] = d[1] ^ d[2] ^ d[3];
    return cw;
  endfunction

endpackage

// File: rtl/hamm_decode_pipe_syndrome.sv
// Combinational Hamming(7,4) syndrome and single-bit correction; parity-bit hits
// leave the data untouched.
module hamm_syndrome
  import hamm_decode_pipe_pkg::*;
(
  input  logic [6:0] cw,
  output logic [2:0] syn,
  output logic       err_data,
  output logic       err_par,
  output logic [3:0] data
);

  always_comb begin
    syn[0]   = cw[P0] ^ cw[D0] ^ cw[D1] ^ cw[D3];
    syn[1]   = cw[P1] ^ cw[D0] ^ cw[D2] ^ cw[D3];
    syn[2]   = cw[P2] ^ cw[D1] ^ cw[D2] ^ cw[D3];
    data     = cw[3:0];
    err_data = 1'b0;
    err_par  = 1'b0;
    case (syn)
      SYN_D0: begin data[D0] = ~cw[D0]; err_data = 1'b1; end
      SYN_D1: begin data[D1] = ~cw[D1]; err_data = 1'b1; end
      SYN_D2: begin data[D2] = ~cw[D2]; err_data = 1'b1; end
      SYN_D3: begin data[D3] = ~cw[D3]; err_data = 1'b1; end
      SYN_P0, SYN_P1, SYN_P2: err_par = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hamm_decode_pipe.sv
// Two-stage Hamming(7,4) decoder: 2-cycle latency, full throughput; a stalled
// output freezes S2 and S1, so in_ready follows out_ready combinationally.
module hamm_decode_pipe
  import hamm_decode_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [2:0]       out_syn,
  output logic             out_err_data,
  output logic             out_err_par,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_data,
  output logic [CNT_W-1:0] cnt_par
);

  logic       s1_valid;
  logic [6:0] s1_cw;
  logic [2:0] fix_syn;
  logic       fix_err_data;
  logic       fix_err_par;
  logic [3:0] fix_data;
  logic       s2_adv;
  logic       s1_adv;
  logic       out_fire;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_cw <= in_cw;
    end
  end

  hamm_syndrome u_syndrome (
    .cw       (s1_cw),
    .syn      (fix_syn),
    .err_data (fix_err_data),
    .err_par  (fix_err_par),
    .data     (fix_data)
  );

  // Payload only reloads with a real word so the outputs stay tidy across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_syn      <= '0;
      out_err_data <= 1'b0;
      out_err_par  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= fix_data;
        out_syn      <= fix_syn;
        out_err_data <= fix_err_data;
        out_err_par  <= fix_err_par;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_data <= '0;
      cnt_par  <= '0;
    end else if (out_fire) begin
      if (out_err_data && (cnt_data != '1)) cnt_data <= cnt_data + CNT_W'(1);
      if (out_err_par && (cnt_par != '1))   cnt_par  <= cnt_par + CNT_W'(1);
    end
  end

endmodule

// File: doc/hamm_decode_pipe.md
Name: hamm_decode_pipe

Overview:
- Pipelined Hamming(7,4) single-error-correcting decoder.
- Sits directly downstream of the error-injection stage: it consumes 7-bit codewords, computes the syndrome, corrects any single flipped bit and delivers the 4-bit data word.
- Upstream and downstream sides each use a valid/ready handshake.
- Keeps saturating counters of corrected data-bit errors and parity-bit errors for the test harness.

Parameters:
- CNT_W, 16, width of each error counter; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_cw is valid
- in_ready  output  1  block accepts in_cw this cycle
- in_cw  input  7  codeword; [3:0]=d3..d0, [6:4]=p2..p0
- out_valid  output  1  output word valid
- out_ready  input  1  consumer accepts output this cycle
- out_data  output  4  corrected data d3..d0
- out_syn  output  3  syndrome {s2,s1,s0} of this word
- out_err_data  output  1  syndrome pointed at a data bit (corrected)
- out_err_par  output  1  syndrome pointed at a parity bit (data unchanged)
- cnt_clr  input  1  synchronous clear of both counters
- cnt_data  output  CNT_W  delivered words with out_err_data=1
- cnt_par  output  CNT_W  delivered words with out_err_par=1

Behaviour:
- Code definition:
  - Parity: p0=d0^d1^d3, p1=d0^d2^d3, p2=d1^d2^d3.
  - Syndrome: s0=p0^d0^d1^d3, s1=p1^d0^d2^d3, s2=p2^d1^d2^d3.
- Syndrome map:
  - 000 → no error.
  - 011 → d0, 101 → d1, 110 → d2, 111 → d3.
  - 001 → p0, 010 → p1, 100 → p2.
  - Exactly one of {none, err_data, err_par} holds per word. Double errors are silently miscorrected; no detection is required.
- Pipeline, two register stages:
  - S1 holds s1_valid, cw and the computed syndrome.
  - S2 is the output register: out_valid, out_data, out_syn and the flags. The flip of data bits is applied on the S1→S2 transfer.
- Advance rules:
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv. This is a combinational path from out_ready and is intentional.
- Transfers:
  - Input is accepted when in_valid & in_ready; S1 loads in_cw and s1_valid←1.
  - If s1_adv and no input is accepted, s1_valid←0.
  - S2 loads from S1 when s2_adv. out_valid←s1_valid.
- Timing:
  - Latency: a word accepted at edge k has out_valid=1 in the cycle following edge k+1.
  - Throughput is 1 word/cycle when out_ready is held high.
- Stall and bubbles:
  - While out_valid & ~out_ready, out_data, out_syn and the flags hold stable, S1 holds, and in_ready=~s1_valid.
  - Bubbles do not collapse ordering. Words are delivered strictly in acceptance order, with none dropped or duplicated.
- Counters:
  - Each counter increments by 1 on an output handshake (out_valid & out_ready) when its flag is set.
  - Each counter saturates at all-ones.
  - cnt_clr has priority over the increment in the same cycle: the counter reads 0 next cycle.
- Reset:
  - Values: out_valid=0, s1_valid=0, out_data=0, out_syn=0, both flags 0, both counters 0.
  - While rst is high, in_ready=1 combinationally is permitted, but no word is captured.
  - Reset mid-operation discards all in-flight words. The first out_valid after rst deasserts is the first word accepted after reset.

Decomposition:
- Shared package: the codeword bit-position constants (D0..D3 = 0..3, P0..P2 = 4..6) and the syndrome constants (SYN_NONE, SYN_D0=3'b011, SYN_D1=3'b101, SYN_D2=3'b110, SYN_D3=3'b111, SYN_P0=3'b001, SYN_P1=3'b010, SYN_P2=3'b100). The encoder and the bench reuse these.
- One natural sub-module, hamm_syndrome: combinational, taking cw[6:0] and producing syn[2:0], err_data, err_par and corrected data[3:0]. It is instantiated between S1 and S2.

Test Plan:
- Clean stream: send cw 0x1B (data 4'b1011, parity 3'b001) and 0x00 with out_ready=1.
  - Expect out_data 4'hB then 4'h0, syn 000, no flags, counters remain 0, latency 2.
- Data error: send 0x19 (0x1B with d1 flipped).
  - Expect out_data 4'hB, syn 101, out_err_data=1, cnt_data=1.
- Parity error: send 0x20 (0x00 with p1 flipped).
  - Expect out_data 4'h0, syn 010, out_err_par=1, cnt_par=1.
- Backpressure: stream 8 words back-to-back while holding out_ready=0 for 5 cycles mid-stream.
  - Expect in_ready low once both stages are full, output held stable, all 8 words delivered in order.
- Counter edges: with CNT_W=2, deliver 5 data-error words.
  - Expect cnt_data=3 (saturated).
  - Then assert cnt_clr in the same cycle as an error handshake: expect 0.
- Reset mid-flight: with 2 words in the pipe, pulse rst for 1 cycle.
  - Expect out_valid=0 and counters 0 the next cycle, and no stale word emerges afterwards.
